// File: rtl/ppa_adder_pipe.sv
// ppa_adder_pipe: pipelined Kogge-Stone (recursive-doubling) adder/subtractor
// with valid/ready flow control. WIDTH is a power of two (4..64); REG_EVERY
// prefix levels are evaluated between pipeline registers.
// Optional feature macro: PPA_OVF_EN builds the two's-complement overflow
// output; without it ovf is tied to 0.
module ppa_adder_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int L  = $clog2(WIDTH);
    localparam int NS = (L + REG_EVERY - 1) / REG_EVERY;

    // vld_pipe[0] is the operand stage, vld_pipe[NS] is the output register
    logic [NS:0]              vld_pipe;
    logic                     adv;

    logic [WIDTH-1:0]         bx, g0, p0;
    logic                     c0;

    // g/p: running group generate/propagate; hs: half-sum a^b' kept for the sum
    logic [NS-1:0][WIDTH-1:0] g_q, p_q, hs_q;
    logic [NS-1:0]            c0_q;
    logic [NS:1][WIDTH-1:0]   g_nx, p_nx;

    logic [WIDTH-1:0]         carry, sum_d;
    logic                     cout_d;

    // every stage moves together; a stalled output freezes the whole pipe
    assign adv       = !vld_pipe[NS] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[NS];

    // operand conditioning and per-bit generate/propagate (kill = ~(g|p))
    always_comb begin
        bx = sub ? ~b : b;
        c0 = sub | cin;
        g0 = a & bx;
        p0 = a ^ bx;
    end

    for (genvar s = 1; s <= NS; s++) begin : g_stage
        localparam int LV0 = (s - 1) * REG_EVERY;
        logic [WIDTH-1:0] gt, pt;

        // REG_EVERY doubling levels; descending i keeps lower bits unmodified
        // while they are still being read, so the update can be in place
        always_comb begin
            gt = g_q[s-1];
            pt = p_q[s-1];
            for (int k = 0; k < REG_EVERY; k++) begin
                if (LV0 + k < L) begin
                    for (int i = WIDTH - 1; i >= (1 << (LV0 + k)); i--) begin
                        gt[i] = gt[i] | (pt[i] & gt[i - (1 << (LV0 + k))]);
                        pt[i] = pt[i] & pt[i - (1 << (LV0 + k))];
                    end
                end
            end
            g_nx[s] = gt;
            p_nx[s] = pt;
        end
    end

    // carry into bit i = G[i-1:0] | P[i-1:0] & c0
    assign carry  = {g_nx[NS][WIDTH-2:0] | (p_nx[NS][WIDTH-2:0] & {(WIDTH-1){c0_q[NS-1]}}),
                     c0_q[NS-1]};
    assign cout_d = g_nx[NS][WIDTH-1] | (p_nx[NS][WIDTH-1] & c0_q[NS-1]);
    assign sum_d  = hs_q[NS-1] ^ carry;

    // pipeline registers; outputs only load real results so they hold across bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            g_q      <= '0;
            p_q      <= '0;
            hs_q     <= '0;
            c0_q     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[NS-1:0], in_valid};
            g_q[0]   <= g0;
            p_q[0]   <= p0;
            hs_q[0]  <= p0;
            c0_q[0]  <= c0;
            for (int s = 1; s < NS; s++) begin
                g_q[s]  <= g_nx[s];
                p_q[s]  <= p_nx[s];
                hs_q[s] <= hs_q[s-1];
                c0_q[s] <= c0_q[s-1];
            end
            if (vld_pipe[NS-1]) begin
                sum  <= sum_d;
                cout <= cout_d;
            end
        end
    end

`ifdef PPA_OVF_EN
    logic ovf_q;

    // overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (adv && vld_pipe[NS-1])
            ovf_q <= carry[WIDTH-1] ^ cout_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ppa_adder_pipe.sv
// Bench for ppa_adder_pipe: a 32-bit/REG_EVERY=2 instance and an 8-bit/
// REG_EVERY=1 instance fed the same beats (low byte for the narrow one),
// both checked against an arithmetic reference via scoreboards.
module tb_ppa_adder_pipe;
`ifdef PPA_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    localparam logic [63:0] NONE = 64'hdead_0000_0000_0000;

    logic        clk, reset, in_valid, cin, sub, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] sum;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  sum8;

    int checks, errors, retired;
    logic [63:0] q32[$], q8[$];

    ppa_adder_pipe #(.WIDTH(32), .REG_EVERY(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    ppa_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid8),
        .out_ready(out_ready), .sum(sum8), .cout(cout8), .ovf(ovf8));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: plain w-bit arithmetic, returns {ovf, cout, sum}
    function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
        logic [64:0] m, xa, yb, t;
        logic [63:0] s;
        logic        co, ov;
        m  = (65'd1 << w) - 65'd1;
        xa = {1'b0, x} & m;
        yb = (sb ? ~{1'b0, y} : {1'b0, y}) & m;
        t  = xa + yb + {64'd0, sb ? 1'b1 : ci};
        s  = t[63:0] & m[63:0];
        co = t[w];
        ov = (xa[w-1] == yb[w-1]) && (s[w-1] != xa[w-1]);
        return ({62'd0, ov & OVF, co} << w) | s;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    // scoreboard: push on accept, pop and compare on retire
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            q32.delete();
            q8.delete();
        end else begin
            if (out_valid && out_ready) begin
                e = (q32.size() != 0) ? q32.pop_front() : NONE;
                chk("res32", {30'd0, ovf, cout, sum}, e);
                retired++;
            end
            if (out_valid8 && out_ready) begin
                e = (q8.size() != 0) ? q8.pop_front() : NONE;
                chk("res8", {54'd0, ovf8, cout8, sum8}, e);
            end
            if (in_valid && in_ready)
                q32.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
            if (in_valid && in_ready8)
                q8.push_back(model(8, {56'd0, a[7:0]}, {56'd0, b[7:0]}, cin, sub));
        end
    end

    // one beat into an idle pipe; checks latency, value and single-cycle valid
    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                            input logic ts, input logic [31:0] es, input logic ec,
                            input logic eo, input logic c8, input logic [7:0] es8,
                            input logic ec8);
        int lat;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        chk("ovf", 64'(ovf), 64'(eo));
        if (c8) begin
            chk("vld8", 64'(out_valid8), 64'd1);
            chk("sum8", 64'(sum8), 64'(es8));
            chk("cout8", 64'(cout8), 64'(ec8));
        end
        @(posedge clk); #1;
        chk("vld_pulse", 64'(out_valid), 64'd0);
    endtask

    // n beats with random valid/ready, or a forced out_ready stall window
    task automatic stream(input int n, input int vpct, input int rpct, input int slo, input int shi);
        int sent, cyc;
        logic acc;
        logic [63:0] held;
        sent = 0; cyc = 0; held = '0;
        while ((sent < n || q32.size() != 0) && cyc < 20000) begin
            if (slo >= 0) out_ready = !(cyc >= slo && cyc <= shi);
            else          out_ready = ($urandom_range(99) < rpct);
            if (!in_valid && sent < n && $urandom_range(99) < vpct) begin
                in_valid = 1'b1;
                a   = rnd_op();
                b   = rnd_op();
                cin = 1'($urandom_range(1));
                sub = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (slo >= 0 && cyc >= slo && cyc <= shi) begin
                chk("stall_rdy", 64'(in_ready), 64'd0);
                chk("stall_vld", 64'(out_valid), 64'd1);
                if (cyc == slo) held = {30'd0, ovf, cout, sum};
                else            chk("stall_hold", {30'd0, ovf, cout, sum}, held);
            end
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("strm_budget", 64'(cyc < 20000), 64'd1);
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        int r0;
        logic seen;
        checks = 0; errors = 0; retired = 0;
        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ovld", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_irdy", 64'(in_ready), 64'd1);

        send_one(32'hffff_ffff, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        send_one(32'h5, 32'h7, 1'b0, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 1'b1, 8'hfe, 1'b0);
        send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7fff_ffff, 1'b1, OVF, 1'b1, 8'hff, 1'b0);
        send_one(32'h7fff_ffff, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, OVF, 1'b1, 8'h00, 1'b1);
        send_one(32'hff, 32'h1, 1'b1, 1'b0, 32'h101, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);

        r0 = retired;
        stream(8, 100, 100, 5, 7);
        chk("stall_count", 64'(retired - r0), 64'd8);

        // three beats in flight, then reset with a beat also presented
        out_ready = 1'b1;
        repeat (3) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("mrst_ovld", 64'(out_valid), 64'd0);
        chk("mrst_sum", 64'(sum), 64'd0);
        chk("mrst_cout", 64'(cout), 64'd0);
        chk("mrst_ovf", 64'(ovf), 64'd0);
        chk("mrst_irdy", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid | out_valid8;
        end
        chk("mrst_quiet", 64'(seen), 64'd0);
        send_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0,
                 1'b1, 8'h89, 1'b0);

        r0 = retired;
        stream(1000, 70, 70, -1, -1);
        chk("rand_count", 64'(retired - r0), 64'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
